// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: funct3 size codes for loads/stores, the
// MEM-stage access FSM states and the default bus acknowledge timeout.
package pipeline_pkg;

  // funct3 encodings of the load/store size field
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // BUSY cycles allowed before an unacknowledged access is abandoned
  localparam int ACK_TIMEOUT_DEFAULT = 255;

  // Data-memory access sequencing
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mau_state_e;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering for the data-memory bus: byte enables and
// replicated write data for stores, alignment/legality check, and byte/half
// selection with sign or zero extension for loads.
module load_store_align
  import pipeline_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] load_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misalign,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
    logic signed [7:0]  b_s;
    logic signed [31:0] b_x;
    b_s = b;
    b_x = 32'(b_s);
    return sgn ? b_x : {24'h0, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
    logic signed [15:0] h_s;
    logic signed [31:0] h_x;
    h_s = h;
    h_x = 32'(h_s);
    return sgn ? h_x : {16'h0, h};
  endfunction

  // Pick the addressed byte and half out of the returned word
  always_comb begin
    byte_sel = load_rdata[7:0];
    case (addr_lo)
      2'd0:    byte_sel = load_rdata[7:0];
      2'd1:    byte_sel = load_rdata[15:8];
      2'd2:    byte_sel = load_rdata[23:16];
      default: byte_sel = load_rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? load_rdata[31:16] : load_rdata[15:0];
  end

  // Size decode: enables, replication, alignment and extension per funct3
  always_comb begin
    be        = 4'b0000;
    wdata     = 32'h0;
    misalign  = 1'b0;
    load_data = 32'h0;
    case (funct3)
      F3_B: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = ext_byte(byte_sel, 1'b1);
      end
      F3_H: begin
        misalign  = addr_lo[0];
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{store_data[15:0]}};
        load_data = ext_half(half_sel, 1'b1);
      end
      F3_W: begin
        misalign  = (addr_lo != 2'b00);
        be        = 4'b1111;
        wdata     = store_data;
        load_data = load_rdata;
      end
      F3_BU: begin
        // unsigned sizes exist only for loads
        misalign  = is_store;
        load_data = ext_byte(byte_sel, 1'b0);
      end
      F3_HU: begin
        misalign  = is_store | addr_lo[0];
        load_data = ext_half(half_sel, 1'b0);
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit. Issues one req/ack bus transaction per
// load/store, stalls the pipeline while it is outstanding, and feeds the
// MEM/WB register. Non-memory instructions pass straight through.
module mem_access_unit
  import pipeline_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic [4:0]  rd_in,
  input  logic        reg_write_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] mem_data_out,
  output logic [4:0]  rd_out,
  output logic [31:0] alu_result_out,
  output logic        reg_write_out,
  output logic        stall_out,
  output logic        misalign_out,
  output logic        bus_err_out
);

  localparam logic [15:0] TIMEOUT_CNT = 16'(ACK_TIMEOUT);

  // control / bus state
  mau_state_e  state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        bus_err_q, bus_err_d;
  logic [15:0] cnt_q, cnt_d;

  // instruction copy held for the DONE cycle
  logic [31:0] data_q, data_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] alu_q, alu_d;
  logic        rw_q, rw_d;
  logic [2:0]  f3_q, f3_d;

  logic        idle;
  logic        mem_op;
  logic        issue;
  logic        fault;
  logic        cnt_expired;
  logic [1:0]  al_addr_lo;
  logic [2:0]  al_funct3;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load;
  logic        al_misalign;

  assign idle   = (state_q == ST_IDLE);
  assign mem_op = ex_valid & (mem_read_in | mem_write_in);
  assign issue  = idle & mem_op & ~al_misalign;
  assign fault  = idle & mem_op & al_misalign;
  assign cnt_expired = ((cnt_q + 16'd1) == TIMEOUT_CNT);

  // Decode the live instruction while idle; extend against the held one while busy
  assign al_addr_lo = idle ? alu_result_in[1:0] : alu_q[1:0];
  assign al_funct3  = idle ? funct3_in : f3_q;

  load_store_align u_align (
    .addr_lo    (al_addr_lo),
    .funct3     (al_funct3),
    .is_store   (mem_write_in),
    .store_data (store_data_in),
    .load_rdata (dmem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .misalign   (al_misalign),
    .load_data  (al_load)
  );

  // Next-state and registered bus outputs for the IDLE/BUSY/DONE sequence
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    be_d      = be_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    bus_err_d = 1'b0;
    cnt_d     = cnt_q;
    data_d    = data_q;
    rd_d      = rd_q;
    alu_d     = alu_q;
    rw_d      = rw_q;
    f3_d      = f3_q;
    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          state_d = ST_BUSY;
          req_d   = 1'b1;
          we_d    = mem_write_in;
          be_d    = mem_write_in ? al_be : 4'b1111;
          addr_d  = {alu_result_in[31:2], 2'b00};
          wdata_d = mem_write_in ? al_wdata : 32'h0;
          cnt_d   = 16'd0;
          data_d  = 32'h0;
          rd_d    = rd_in;
          alu_d   = alu_result_in;
          rw_d    = reg_write_in;
          f3_d    = funct3_in;
        end
      end
      ST_BUSY: begin
        if (dmem_ack || cnt_expired) begin
          state_d = ST_DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          be_d    = 4'b0000;
          addr_d  = 32'h0;
          wdata_d = 32'h0;
        end
        if (dmem_ack) begin
          if (!we_q) data_d = al_load;
        end else begin
          cnt_d     = cnt_q + 16'd1;
          bus_err_d = cnt_expired;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and bus registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= 4'b0000;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      bus_err_q <= 1'b0;
      cnt_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      be_q      <= be_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      bus_err_q <= bus_err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Held instruction fields and load data; only observed in DONE
  always_ff @(posedge clk) begin
    data_q <= data_d;
    rd_q   <= rd_d;
    alu_q  <= alu_d;
    rw_q   <= rw_d;
    f3_q   <= f3_d;
  end

  // MEM/WB-facing outputs: pass-through when idle, held results in DONE
  always_comb begin
    stall_out    = issue | (state_q == ST_BUSY);
    misalign_out = fault;
    if (state_q == ST_DONE) begin
      mem_data_out   = data_q;
      rd_out         = rd_q;
      alu_result_out = alu_q;
      reg_write_out  = rw_q & ~bus_err_q;
    end else begin
      mem_data_out   = 32'h0;
      rd_out         = rd_in;
      alu_result_out = alu_result_in;
      reg_write_out  = idle & ex_valid & reg_write_in & ~mem_op;
    end
  end

  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_be     = be_q;
  assign dmem_addr   = addr_q;
  assign dmem_wdata  = wdata_q;
  assign bus_err_out = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases followed by random loads/stores
// checked against a size/alignment reference model.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [2:0]  funct3_in;
  logic [31:0] alu_result_in;
  logic [31:0] store_data_in;
  logic [4:0]  rd_in;
  logic        reg_write_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic [31:0] mem_data_out;
  logic [4:0]  rd_out;
  logic [31:0] alu_result_out;
  logic        reg_write_out;
  logic        stall_out;
  logic        misalign_out;
  logic        bus_err_out;

  int checks;
  int failures;

  mem_access_unit #(.ACK_TIMEOUT(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .ex_valid       (ex_valid),
    .mem_read_in    (mem_read_in),
    .mem_write_in   (mem_write_in),
    .funct3_in      (funct3_in),
    .alu_result_in  (alu_result_in),
    .store_data_in  (store_data_in),
    .rd_in          (rd_in),
    .reg_write_in   (reg_write_in),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_be        (dmem_be),
    .dmem_rdata     (dmem_rdata),
    .dmem_ack       (dmem_ack),
    .mem_data_out   (mem_data_out),
    .rd_out         (rd_out),
    .alu_result_out (alu_result_out),
    .reg_write_out  (reg_write_out),
    .stall_out      (stall_out),
    .misalign_out   (misalign_out),
    .bus_err_out    (bus_err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    ex_valid      = 1'b0;
    mem_read_in   = 1'b0;
    mem_write_in  = 1'b0;
    funct3_in     = 3'd0;
    alu_result_in = 32'h0;
    store_data_in = 32'h0;
    rd_in         = 5'd0;
    reg_write_in  = 1'b0;
    dmem_ack      = 1'b0;
    dmem_rdata    = 32'h0;
  endtask

  // Access width in bytes, 0 when the funct3 is not usable for this direction
  function automatic int access_bytes(input bit st, input logic [2:0] f3);
    case (f3)
      3'd0:    return 1;
      3'd1:    return 2;
      3'd2:    return 4;
      3'd4:    return st ? 0 : 1;
      3'd5:    return st ? 0 : 2;
      default: return 0;
    endcase
  endfunction

  function automatic bit legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = access_bytes(st, f3);
    if (sz == 0) return 1'b0;
    return (int'(a[1:0]) % sz) == 0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rdata);
    logic [31:0] v;
    int x;
    v = rdata >> (8 * int'(a[1:0]));
    case (f3)
      3'd0: begin
        x = int'(v & 32'hFF);
        if (x >= 128) x = x - 256;
      end
      3'd1: begin
        x = int'(v & 32'hFFFF);
        if (x >= 32768) x = x - 65536;
      end
      3'd4:    x = int'(v & 32'hFF);
      3'd5:    x = int'(v & 32'hFFFF);
      default: x = int'(rdata);
    endcase
    return 32'(x);
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'd0:    return 4'(1 << int'(a[1:0]));
      3'd1:    return (int'(a[1:0]) == 2) ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'd0:    return (d & 32'hFF) * 32'h0101_0101;
      3'd1:    return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  // One instruction through the unit; ack_at is the BUSY cycle index that acks (>= TO: never)
  task automatic run_op(input string nm, input bit v, input bit rdop, input bit wrop,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                        input logic [4:0] rdi, input bit rw, input logic [31:0] rdata,
                        input int ack_at);
    bit memop;
    bit st;
    bit acked;
    int busy_n;
    int stalls;
    logic [31:0] exp_md;
    memop = v && (rdop || wrop);
    st    = wrop;
    @(posedge clk); #1;
    ex_valid      = v;
    mem_read_in   = rdop;
    mem_write_in  = wrop;
    funct3_in     = f3;
    alu_result_in = a;
    store_data_in = sd;
    rd_in         = rdi;
    reg_write_in  = rw;
    dmem_ack      = 1'b0;
    dmem_rdata    = rdata;
    #1;
    chk({nm, ".req_issue"}, 32'(dmem_req), 32'd0);
    if (!memop) begin
      chk({nm, ".rd"}, 32'(rd_out), 32'(rdi));
      chk({nm, ".alu"}, alu_result_out, a);
      chk({nm, ".rw"}, 32'(reg_write_out), 32'(v && rw));
      chk({nm, ".stall"}, 32'(stall_out), 32'd0);
      chk({nm, ".misalign"}, 32'(misalign_out), 32'd0);
      chk({nm, ".mdata"}, mem_data_out, 32'd0);
    end else if (!legal(st, f3, a)) begin
      chk({nm, ".misalign"}, 32'(misalign_out), 32'd1);
      chk({nm, ".stall"}, 32'(stall_out), 32'd0);
      chk({nm, ".rw"}, 32'(reg_write_out), 32'd0);
    end else begin
      chk({nm, ".misalign"}, 32'(misalign_out), 32'd0);
      chk({nm, ".rw_issue"}, 32'(reg_write_out), 32'd0);
      stalls = stall_out ? 1 : 0;
      busy_n = 0;
      acked  = 1'b0;
      while (!acked && busy_n < TO) begin
        @(posedge clk); #1;
        dmem_ack = (busy_n == ack_at);
        #1;
        chk({nm, ".req"}, 32'(dmem_req), 32'd1);
        chk({nm, ".addr"}, dmem_addr, a & ~32'd3);
        chk({nm, ".we"}, 32'(dmem_we), 32'(st));
        if (st) begin
          chk({nm, ".be"}, 32'(dmem_be), 32'(exp_be(f3, a)));
          chk({nm, ".wdata"}, dmem_wdata, exp_wdata(f3, sd));
        end
        chk({nm, ".rw_busy"}, 32'(reg_write_out), 32'd0);
        if (stall_out) stalls++;
        acked = dmem_ack;
        busy_n++;
      end
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      #1;
      exp_md = (!st && acked) ? exp_load(f3, a, rdata) : 32'd0;
      chk({nm, ".req_done"}, 32'(dmem_req), 32'd0);
      chk({nm, ".stall_done"}, 32'(stall_out), 32'd0);
      chk({nm, ".mdata"}, mem_data_out, exp_md);
      chk({nm, ".rd_done"}, 32'(rd_out), 32'(rdi));
      chk({nm, ".alu_done"}, alu_result_out, a);
      chk({nm, ".rw_done"}, 32'(reg_write_out), 32'(rw && acked));
      chk({nm, ".bus_err"}, 32'(bus_err_out), 32'(!acked));
      chk({nm, ".stall_cycles"}, 32'(stalls), 32'(1 + busy_n));
    end
    @(posedge clk); #1;
    drive_idle();
    #1;
    chk({nm, ".stall_after"}, 32'(stall_out), 32'd0);
    chk({nm, ".misalign_after"}, 32'(misalign_out), 32'd0);
    chk({nm, ".bus_err_after"}, 32'(bus_err_out), 32'd0);
    chk({nm, ".req_after"}, 32'(dmem_req), 32'd0);
  endtask

  int k;
  bit rv;
  bit rr;
  bit rwr;
  bit rrw;
  logic [2:0]  rf3;
  logic [31:0] ra;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.req", 32'(dmem_req), 32'd0);
    chk("rst.we", 32'(dmem_we), 32'd0);
    chk("rst.be", 32'(dmem_be), 32'd0);
    chk("rst.addr", dmem_addr, 32'd0);
    chk("rst.wdata", dmem_wdata, 32'd0);
    chk("rst.stall", 32'(stall_out), 32'd0);
    chk("rst.misalign", 32'(misalign_out), 32'd0);
    chk("rst.bus_err", 32'(bus_err_out), 32'd0);
    chk("rst.rw", 32'(reg_write_out), 32'd0);
    chk("rst.mdata", mem_data_out, 32'd0);
    reset = 1'b0;

    run_op("add",   1, 0, 0, 3'd0, 32'h0000_1234, 32'h0,         5'd5,  1, 32'h0,         0);
    run_op("novld", 0, 1, 0, 3'd2, 32'h0000_0040, 32'h0,         5'd7,  1, 32'h0,         0);
    run_op("lb",    1, 1, 0, 3'd0, 32'h0000_0103, 32'h0,         5'd9,  1, 32'h80FF_00AA, 0);
    run_op("lbu",   1, 1, 0, 3'd4, 32'h0000_0103, 32'h0,         5'd9,  1, 32'h80FF_00AA, 0);
    run_op("sh",    1, 0, 1, 3'd1, 32'h0000_0022, 32'hABCD_1234, 5'd0,  0, 32'h0,         0);
    run_op("sb",    1, 0, 1, 3'd0, 32'h0000_0011, 32'h1122_33C4, 5'd0,  0, 32'h0,         1);
    run_op("lh",    1, 1, 0, 3'd1, 32'h0000_0302, 32'h0,         5'd3,  1, 32'h9234_5678, 2);
    run_op("lhu",   1, 1, 0, 3'd5, 32'h0000_0302, 32'h0,         5'd3,  1, 32'h9234_5678, 0);
    run_op("lw",    1, 1, 0, 3'd2, 32'h0000_0440, 32'h0,         5'd12, 1, 32'hDEAD_BEEF, 3);
    run_op("lw_mis",1, 1, 0, 3'd2, 32'h0000_0041, 32'h0,         5'd4,  1, 32'h0,         0);
    run_op("lf3",   1, 1, 0, 3'd3, 32'h0000_0040, 32'h0,         5'd4,  1, 32'h0,         0);
    run_op("sbu",   1, 0, 1, 3'd4, 32'h0000_0040, 32'h55,        5'd0,  0, 32'h0,         0);
    run_op("both",  1, 1, 1, 3'd2, 32'h0000_0080, 32'hCAFE_F00D, 5'd6,  1, 32'h1234_5678, 0);
    run_op("lw_to", 1, 1, 0, 3'd2, 32'h0000_0500, 32'h0,         5'd8,  1, 32'h1111_2222, TO);

    // reset while an access is outstanding, then a late acknowledge
    @(posedge clk); #1;
    ex_valid      = 1'b1;
    mem_read_in   = 1'b1;
    funct3_in     = 3'd2;
    alu_result_in = 32'h0000_0200;
    rd_in         = 5'd11;
    reg_write_in  = 1'b1;
    dmem_rdata    = 32'h7777_7777;
    #1;
    chk("rbusy.stall_issue", 32'(stall_out), 32'd1);
    @(posedge clk); #1;
    chk("rbusy.req", 32'(dmem_req), 32'd1);
    reset = 1'b1;
    drive_idle();
    dmem_rdata = 32'h7777_7777;
    #1;
    chk("rbusy.req_async", 32'(dmem_req), 32'd0);
    chk("rbusy.stall_async", 32'(stall_out), 32'd0);
    @(posedge clk); #1;
    reset    = 1'b0;
    dmem_ack = 1'b1;
    #1;
    chk("rbusy.req_ack", 32'(dmem_req), 32'd0);
    chk("rbusy.stall_ack", 32'(stall_out), 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    #1;
    chk("rbusy.req_post", 32'(dmem_req), 32'd0);
    chk("rbusy.mdata_post", mem_data_out, 32'd0);
    chk("rbusy.rw_post", 32'(reg_write_out), 32'd0);
    chk("rbusy.bus_err_post", 32'(bus_err_out), 32'd0);
    chk("rbusy.stall_post", 32'(stall_out), 32'd0);

    // random mix of pass-through, loads, stores and illegal accesses
    for (int i = 0; i < 40; i++) begin
      k   = $urandom_range(0, 9);
      rv  = ($urandom_range(0, 7) != 0);
      rrw = ($urandom_range(0, 1) != 0);
      rr  = (k >= 3 && k < 6) || (k == 9);
      rwr = (k >= 6);
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom;
      if ($urandom_range(0, 1) != 0) ra[0] = 1'b0;
      if ($urandom_range(0, 3) != 0) ra[1] = 1'b0;
      run_op("rnd", rv, rr, rwr, rf3, ra, $urandom, 5'($urandom_range(0, 31)), rrw,
             $urandom, $urandom_range(0, TO));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
